digit_scan_ctrl: RTL and testbench
==================================

Name: digit_scan_ctrl

Overview:
- Parametrised multiplexed-display digit scanner. Next generation of the team's one-hot ring counter.
- Drives a one-hot (or one-cold) digit-select bus for N-digit 7-segment displays.
- Adds a per-digit dwell prescaler, optional dead-time blanking between digits, scan direction, per-digit enable mask with skipping, and a frame-start strobe.
- Sits between the clock/tick source and the segment mux; idx selects the segment data for the active digit.

Parameters:
DIGITS, 4, number of digits scanned; legal 2..16
DWELL, 1000, enabled cycles each digit stays active; legal >= 1
DEAD, 0, enabled cycles of all-digits-off between digits; legal 0..255; 0 means no dead-time state
ACTIVE_LOW, 1, 1: active digit driven 0, others 1; 0: active digit driven 1, others 0

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset; synchronous and active-high
enabled  in  1  cycle qualifier; when 0 all state and outputs hold
dir  in  1  0: scan toward higher idx; 1: toward lower idx
mask  in  DIGITS  1 = digit participates in scan; 0 = skipped and kept off
sel  out  DIGITS  registered digit-select bus, polarity per ACTIVE_LOW
idx  out  IW  registered index of current digit; IW = max(1, clog2(DIGITS))
frame_start  out  1  registered one-cycle pulse on first SHOW cycle after a scan wrap
blanking  out  1  registered; 1 while in DEAD state or when no digit is enabled

Behaviour:
- One clock, synchronous active-high rst; rst has priority over enabled.
- Reset values: idx=0, state=SHOW, dwell_cnt=0, dead_cnt=0, sel = digit 0 active and others inactive (ACTIVE_LOW=1, DIGITS=4: 4'b1110), frame_start=0, blanking=0.
- Reset values do not depend on mask. From the first post-reset cycle, mask gating applies.
- enabled=0: counters, state, idx, sel and blanking hold. frame_start is forced 0 (pulse never stretched).
- States: SHOW, DEAD.
- SHOW: dwell_cnt increments each enabled cycle.
  - At dwell_cnt==DWELL-1 with DEAD>0: next state DEAD, dead_cnt=0, sel all inactive, blanking=1.
  - At dwell_cnt==DWELL-1 with DEAD==0: advance directly. dwell_cnt resets to 0 and state stays SHOW.
  - DWELL==1: advance every enabled cycle.
- DEAD: dead_cnt increments each enabled cycle. At dead_cnt==DEAD-1: advance, state SHOW, dwell_cnt=0, blanking=0.
- Advance rule:
  - Next idx is the first index with mask=1, searching from idx±1 in direction dir, wrapping modulo DIGITS, through DIGITS-1 steps, then idx itself.
  - idx never exceeds DIGITS-1, including non-power-of-two DIGITS.
  - mask sampled at the advance cycle; dir likewise. A dir change mid-dwell affects only the next advance.
- Wrap and frame_start:
  - A wrap is a search that crosses DIGITS-1→0 (dir=0) or 0→DIGITS-1 (dir=1).
  - A single enabled digit re-selecting itself counts as a wrap.
  - frame_start=1 for exactly the first SHOW cycle following a wrapping advance.
- No digit enabled (mask all 0) at advance: idx holds, sel all inactive, blanking=1, no frame_start. Timing continues so that re-enabling resumes at the next advance.
- Live mask in SHOW:
  - sel[idx] is active iff mask[idx]=1. A mask change on the current digit reaches sel one cycle later (registered). Dwell timing is unaffected.
  - If mask[idx]=0 while in SHOW, blanking=1.
- At most one sel bit is ever active. In DEAD, all sel bits are inactive.
- Steady-state period per digit: DWELL+DEAD enabled cycles.

Test Plan:
- DIGITS=4, DWELL=3, DEAD=0, ACTIVE_LOW=1, mask=4'b1111, dir=0, enabled=1 after rst -> sel runs 1110 for 3 cycles, then 1101, 1011, 0111 (3 cycles each), then 1110; idx 0,1,2,3,0; frame_start=1 on the first cycle of the second 1110 only.
- Same with DEAD=1 -> after each 3 SHOW cycles, 1 cycle of sel=1111 and blanking=1; 16-cycle frame; no two sel bits ever 0 together.
- dir=1, mask=4'b1011, DEAD=0 -> idx sequence 0,3,1,0,3 (digit 2 skipped, sel bit 2 stays 1); frame_start on each entry to idx 3.
- mask=4'b0000 mid-scan -> sel=1111 and blanking=1 one cycle later; idx frozen at advances. Restore mask=4'b0100 -> next advance selects idx 2 and pulses frame_start on every advance (single-digit wrap).
- enabled toggled 1/0 every cycle with DWELL=3 -> each digit active 6 clk cycles; frame_start high only in enabled cycles, never 2 cycles.
- rst asserted mid-DEAD with enabled=0 -> next cycle idx=0, sel=1110, blanking=0, counters 0. DIGITS=5 (ACTIVE_LOW=0) wrap: idx 4→0, sel 10000→00001.

Source files
------------

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: multiplexed-display digit scanner.
// Walks a one-hot/one-cold digit-select bus across DIGITS digits with a
// per-digit dwell, optional dead-time blanking, scan direction, per-digit
// enable mask (disabled digits are skipped) and a frame-start strobe.
module digit_scan_ctrl #(
    parameter int DIGITS     = 4,
    parameter int DWELL      = 1000,
    parameter int DEAD       = 0,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         enabled,
    input  logic                                         dir,
    input  logic [DIGITS-1:0]                            mask,
    output logic [DIGITS-1:0]                            sel,
    output logic [((DIGITS > 2) ? $clog2(DIGITS) : 1)-1:0] idx,
    output logic                                         frame_start,
    output logic                                         blanking
);

    localparam int IW = (DIGITS > 2) ? $clog2(DIGITS) : 1;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [DW-1:0]     DWELL_LAST = DW'(DWELL - 1);
    localparam logic [7:0]        DEAD_LAST  = 8'((DEAD > 0) ? DEAD - 1 : 0);
    localparam logic [DIGITS-1:0] ONE        = DIGITS'(1);
    localparam logic [DIGITS-1:0] SEL_RST    = (ACTIVE_LOW != 0) ? ~ONE : ONE;

    typedef enum logic {
        S_SHOW,
        S_DEAD
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     dwell_q, dwell_d;
    logic [7:0]        dead_q, dead_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic              fs_q, fs_d;
    logic              blank_q, blank_d;

    logic              advance;
    logic              found;
    logic [IW-1:0]     nxt;
    logic [DIGITS-1:0] act;

    // Timing, next-digit search and registered output values
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        dead_d  = dead_q;
        idx_d   = idx_q;
        advance = 1'b0;
        fs_d    = 1'b0;
        found   = 1'b0;
        nxt     = idx_q;
        act     = '0;

        if (state_q == S_SHOW) begin
            if (dwell_q == DWELL_LAST) begin
                dwell_d = '0;
                if (DEAD > 0) begin
                    state_d = S_DEAD;
                    dead_d  = '0;
                end else begin
                    advance = 1'b1;
                end
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end else begin
            if (dead_q == DEAD_LAST) begin
                advance = 1'b1;
                state_d = S_SHOW;
                dwell_d = '0;
                dead_d  = '0;
            end else begin
                dead_d = dead_q + 1'b1;
            end
        end

        // Search idx+-1 onward in scan direction; step DIGITS lands back on idx
        for (int unsigned k = 1; k <= DIGITS; k++) begin
            int unsigned c;
            if (!dir) c = (int'(idx_q) + k) % DIGITS;
            else      c = (int'(idx_q) + DIGITS - k) % DIGITS;
            if (!found && mask[c]) begin
                found = 1'b1;
                nxt   = IW'(c);
            end
        end

        // A wrap lands at or behind the starting digit in scan direction
        if (advance && found) begin
            idx_d = nxt;
            fs_d  = dir ? (nxt >= idx_q) : (nxt <= idx_q);
        end

        if (state_d == S_SHOW && mask[idx_d]) begin
            act = ONE << idx_d;
        end
        sel_d   = (ACTIVE_LOW != 0) ? ~act : act;
        blank_d = (state_d == S_DEAD) || !mask[idx_d];
    end

    // State and output registers; enabled=0 holds everything but frame_start
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_SHOW;
            dwell_q <= '0;
            dead_q  <= '0;
            idx_q   <= '0;
            sel_q   <= SEL_RST;
            fs_q    <= 1'b0;
            blank_q <= 1'b0;
        end else if (enabled) begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            dead_q  <= dead_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            fs_q    <= fs_d;
            blank_q <= blank_d;
        end else begin
            fs_q <= 1'b0;
        end
    end

    assign sel         = sel_q;
    assign idx         = idx_q;
    assign frame_start = fs_q;
    assign blanking    = blank_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: directed tests over three scanner configurations.
module tb_digit_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // A: 4 digits, dwell 3, no dead time, active-low
    logic       rstA, enA, dirA, fsA, blkA;
    logic [3:0] maskA, selA;
    logic [1:0] idxA;
    // B: 4 digits, dwell 3, dead 1, active-low
    logic       rstB, enB, dirB, fsB, blkB;
    logic [3:0] maskB, selB;
    logic [1:0] idxB;
    // C: 5 digits, dwell 1, no dead time, active-high
    logic       rstC, enC, dirC, fsC, blkC;
    logic [4:0] maskC, selC;
    logic [2:0] idxC;

    digit_scan_ctrl #(.DIGITS(4), .DWELL(3), .DEAD(0), .ACTIVE_LOW(1)) dutA (
        .clk(clk), .rst(rstA), .enabled(enA), .dir(dirA), .mask(maskA),
        .sel(selA), .idx(idxA), .frame_start(fsA), .blanking(blkA));

    digit_scan_ctrl #(.DIGITS(4), .DWELL(3), .DEAD(1), .ACTIVE_LOW(1)) dutB (
        .clk(clk), .rst(rstB), .enabled(enB), .dir(dirB), .mask(maskB),
        .sel(selB), .idx(idxB), .frame_start(fsB), .blanking(blkB));

    digit_scan_ctrl #(.DIGITS(5), .DWELL(1), .DEAD(0), .ACTIVE_LOW(0)) dutC (
        .clk(clk), .rst(rstC), .enabled(enC), .dir(dirC), .mask(maskC),
        .sel(selC), .idx(idxC), .frame_start(fsC), .blanking(blkC));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rstA = 1'b1; enA = 1'b0; step(); rstA = 1'b0; enA = 1'b1;
    endtask

    task automatic reset_b();
        rstB = 1'b1; enB = 1'b0; step(); rstB = 1'b0; enB = 1'b1;
    endtask

    task automatic test_reset();
        maskA = 4'b0000; maskB = 4'b0000; maskC = 5'b00000;
        rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
        enA = 1'b1; enB = 1'b1; enC = 1'b1;
        step();
        checks++;
        if (selA !== 4'b1110 || idxA !== 2'd0 || fsA !== 1'b0 || blkA !== 1'b0) begin
            failures++;
            $display("FAIL reset_A sel=%b idx=%0d fs=%b blk=%b exp sel=1110 idx=0 fs=0 blk=0", selA, idxA, fsA, blkA);
        end
        checks++;
        if (selB !== 4'b1110 || idxB !== 2'd0 || fsB !== 1'b0 || blkB !== 1'b0) begin
            failures++;
            $display("FAIL reset_B sel=%b idx=%0d fs=%b blk=%b exp sel=1110 idx=0 fs=0 blk=0", selB, idxB, fsB, blkB);
        end
        checks++;
        if (selC !== 5'b00001 || idxC !== 3'd0 || fsC !== 1'b0 || blkC !== 1'b0) begin
            failures++;
            $display("FAIL reset_C sel=%b idx=%0d fs=%b blk=%b exp sel=00001 idx=0 fs=0 blk=0", selC, idxC, fsC, blkC);
        end
        rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
        enA = 1'b0; enB = 1'b0; enC = 1'b0;
    endtask

    task automatic test_scan();
        logic [3:0] exp_sel;
        int         exp_idx;
        maskA = 4'b1111; dirA = 1'b0;
        reset_a();
        for (int t = 0; t < 15; t++) begin
            exp_idx = (t / 3) % 4;
            exp_sel = ~(4'b0001 << exp_idx);
            checks++;
            if (selA !== exp_sel || int'(idxA) != exp_idx || fsA !== (t == 12) || blkA !== 1'b0) begin
                failures++;
                $display("FAIL scan t=%0d sel=%b idx=%0d fs=%b blk=%b exp sel=%b idx=%0d fs=%b blk=0",
                         t, selA, idxA, fsA, blkA, exp_sel, exp_idx, (t == 12));
            end
            step();
        end
    endtask

    task automatic test_dead_time();
        logic [3:0] exp_sel;
        logic       exp_blk;
        int         d;
        maskB = 4'b1111; dirB = 1'b0;
        reset_b();
        for (int t = 0; t < 18; t++) begin
            d       = (t / 4) % 4;
            exp_blk = ((t % 4) == 3);
            exp_sel = exp_blk ? 4'b1111 : ~(4'b0001 << d);
            checks++;
            if (selB !== exp_sel || blkB !== exp_blk || int'(idxB) != d || fsB !== (t == 16)
                || $countones(~selB) > 1) begin
                failures++;
                $display("FAIL dead t=%0d sel=%b idx=%0d fs=%b blk=%b exp sel=%b idx=%0d fs=%b blk=%b",
                         t, selB, idxB, fsB, blkB, exp_sel, d, (t == 16), exp_blk);
            end
            step();
        end
    endtask

    task automatic test_dir_mask();
        int seq [5] = '{0, 3, 1, 0, 3};
        int exp_idx;
        logic [3:0] exp_sel;
        maskA = 4'b1011; dirA = 1'b1;
        reset_a();
        for (int t = 0; t < 15; t++) begin
            exp_idx = seq[t / 3];
            exp_sel = ~(4'b0001 << exp_idx);
            checks++;
            if (selA !== exp_sel || int'(idxA) != exp_idx || fsA !== (t == 3 || t == 12) || selA[2] !== 1'b1) begin
                failures++;
                $display("FAIL dir_mask t=%0d sel=%b idx=%0d fs=%b exp sel=%b idx=%0d fs=%b",
                         t, selA, idxA, fsA, exp_sel, exp_idx, (t == 3 || t == 12));
            end
            step();
        end
        dirA = 1'b0;
    endtask

    task automatic test_mask_off();
        logic [3:0] exp_sel;
        logic       exp_blk, exp_fs;
        int         exp_idx;
        maskA = 4'b1111; dirA = 1'b0;
        reset_a();
        for (int t = 0; t < 16; t++) begin
            if (t == 4) maskA = 4'b0000;
            if (t == 7) maskA = 4'b0100;
            if (t >= 5) begin
                exp_idx = (t <= 8) ? 1 : 2;
                exp_blk = (t <= 8);
                exp_sel = (t <= 8) ? 4'b1111 : 4'b1011;
                exp_fs  = (t == 12 || t == 15);
                checks++;
                if (selA !== exp_sel || int'(idxA) != exp_idx || blkA !== exp_blk || fsA !== exp_fs) begin
                    failures++;
                    $display("FAIL mask_off t=%0d sel=%b idx=%0d fs=%b blk=%b exp sel=%b idx=%0d fs=%b blk=%b",
                             t, selA, idxA, fsA, blkA, exp_sel, exp_idx, exp_fs, exp_blk);
                end
            end
            step();
        end
    endtask

    task automatic test_enable_toggle();
        int exp_idx;
        maskA = 4'b1111; dirA = 1'b0;
        reset_a();
        for (int t = 0; t < 31; t++) begin
            enA     = ((t % 2) == 0);
            exp_idx = ((t + 1) / 6) % 4;
            checks++;
            if (int'(idxA) != exp_idx || selA !== ~(4'b0001 << exp_idx) || fsA !== (t == 23)) begin
                failures++;
                $display("FAIL en_toggle t=%0d idx=%0d sel=%b fs=%b exp idx=%0d fs=%b",
                         t, idxA, selA, fsA, exp_idx, (t == 23));
            end
            step();
        end
        enA = 1'b0;
    endtask

    task automatic test_reset_in_dead();
        maskB = 4'b1111; dirB = 1'b0;
        reset_b();
        for (int t = 0; t < 7; t++) step();
        checks++;
        if (selB !== 4'b1111 || blkB !== 1'b1 || idxB !== 2'd1) begin
            failures++;
            $display("FAIL pre_rst_dead sel=%b blk=%b idx=%0d exp sel=1111 blk=1 idx=1", selB, blkB, idxB);
        end
        rstB = 1'b1; enB = 1'b0;
        step();
        checks++;
        if (selB !== 4'b1110 || idxB !== 2'd0 || blkB !== 1'b0 || fsB !== 1'b0) begin
            failures++;
            $display("FAIL rst_dead sel=%b idx=%0d blk=%b fs=%b exp sel=1110 idx=0 blk=0 fs=0", selB, idxB, blkB, fsB);
        end
        rstB = 1'b0; enB = 1'b1;
        for (int t = 0; t < 5; t++) begin
            checks++;
            if (selB !== ((t == 3) ? 4'b1111 : (t == 4) ? 4'b1101 : 4'b1110)) begin
                failures++;
                $display("FAIL post_rst t=%0d sel=%b exp=%b", t, selB,
                         ((t == 3) ? 4'b1111 : (t == 4) ? 4'b1101 : 4'b1110));
            end
            step();
        end
        enB = 1'b0;
    endtask

    task automatic test_wrap_five();
        logic [4:0] exp_sel;
        maskC = 5'b11111; dirC = 1'b0;
        rstC = 1'b1; enC = 1'b0; step(); rstC = 1'b0; enC = 1'b1;
        for (int t = 0; t < 11; t++) begin
            exp_sel = 5'b00001 << (t % 5);
            checks++;
            if (int'(idxC) != (t % 5) || selC !== exp_sel || fsC !== (t == 5 || t == 10) || blkC !== 1'b0) begin
                failures++;
                $display("FAIL wrap5 t=%0d idx=%0d sel=%b fs=%b exp idx=%0d sel=%b fs=%b",
                         t, idxC, selC, fsC, t % 5, exp_sel, (t == 5 || t == 10));
            end
            step();
        end
        enC = 1'b0;
    endtask

    initial begin
        rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
        enA = 1'b0; enB = 1'b0; enC = 1'b0;
        dirA = 1'b0; dirB = 1'b0; dirC = 1'b0;
        maskA = '1; maskB = '1; maskC = '1;
        test_reset();
        test_scan();
        test_dead_time();
        test_dir_mask();
        test_mask_off();
        test_enable_toggle();
        test_reset_in_dead();
        test_wrap_five();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
